// File: rtl/spi_slave.sv
// spi_slave: byte-oriented SPI target front end.
// SCK, CS_n and MOSI are oversampled in the i_Clk domain. Received bytes
// appear on o_RX_Byte with a one-cycle o_RX_DV strobe. The byte in tx_hold
// is shifted out on o_SPI_MISO, MSB first. SPI_MODE selects CPOL/CPHA.
module spi_slave #(
    parameter int SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_SPI_Clk,
    output logic       o_SPI_MISO,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n
);

    // Idle SCK level and which edge samples MOSI.
    localparam logic CPOL = SPI_MODE[1];
    localparam logic CPHA = SPI_MODE[0];

    // Synchroniser stages. All three inputs share the same depth so the
    // MOSI/SCK phase relationship seen at the pins is preserved internally.
    logic       sck_p0;
    logic       sck_p1;
    logic       sck_hist;
    logic       cs_p0;
    logic       cs_p1;
    logic       mosi_p0;
    logic       mosi_p1;

    // Decoded SCK events, already qualified by an active chip select.
    logic       sck_edge;
    logic       lead_edge;
    logic       trail_edge;
    logic       sample_edge;

    // Receive state.
    logic [2:0] rx_cnt;
    logic [6:0] rx_shift;
    logic       rx_done;

    // Transmit state.
    logic [7:0] tx_hold;
    logic [2:0] tx_idx;

    // Two-flop synchronisers plus one history flop on SCK for edge detection.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sck_p0   <= CPOL;
            sck_p1   <= CPOL;
            sck_hist <= CPOL;
            cs_p0    <= 1'b1;
            cs_p1    <= 1'b1;
            mosi_p0  <= 1'b0;
            mosi_p1  <= 1'b0;
        end else begin
            sck_p0   <= i_SPI_Clk;
            sck_p1   <= sck_p0;
            sck_hist <= sck_p1;
            cs_p0    <= i_SPI_CS_n;
            cs_p1    <= cs_p0;
            mosi_p0  <= i_SPI_MOSI;
            mosi_p1  <= mosi_p0;
        end
    end

    // Classify synchronised SCK transitions as leading/trailing; ignore them while deselected.
    always_comb begin
        sck_edge    = (sck_p1 != sck_hist) && !cs_p1;
        lead_edge   = sck_edge && (sck_p1 != CPOL);
        trail_edge  = sck_edge && (sck_p1 == CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        rx_done     = sample_edge && (rx_cnt == 3'd7);
    end

    // Bit counter and shift register; a CS deassert discards any partial byte.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_cnt   <= 3'd0;
            rx_shift <= 7'd0;
        end else if (cs_p1) begin
            rx_cnt   <= 3'd0;
            rx_shift <= 7'd0;
        end else if (sample_edge) begin
            rx_cnt   <= rx_cnt + 3'd1;
            rx_shift <= {rx_shift[5:0], mosi_p1};
        end
    end

    // Publish the completed byte with a single-cycle strobe; the byte holds until the next one.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_RX_DV   <= 1'b0;
            o_RX_Byte <= 8'h00;
        end else begin
            o_RX_DV <= rx_done;
            if (rx_done) begin
                o_RX_Byte <= {rx_shift, mosi_p1};
            end
        end
    end

    // Holding register for the outgoing byte; loads regardless of CS, last load wins.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_hold <= 8'h00;
        end else if (i_TX_DV) begin
            tx_hold <= i_TX_Byte;
        end
    end

    // Bit index walks 7..0 on trailing edges and wraps, so each byte restarts at the MSB.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_idx <= 3'd7;
        end else if (cs_p1) begin
            tx_idx <= 3'd7;
        end else if (trail_edge) begin
            tx_idx <= tx_idx - 3'd1;
        end
    end

    // MISO reads tx_hold live, so a reload between bytes shows up on the next bit driven.
    assign o_SPI_MISO = cs_p1 ? 1'bz : tx_hold[tx_idx];

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized scoreboard bench for spi_slave in modes 0 and 3.
// The SPI master is modelled at bit level; expected received bytes (with the
// cycle they must appear) are queued when the last sample edge is driven and
// a monitor per instance pops and compares on every o_RX_DV pulse.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       mosi = 1'b0;
    logic       sck0 = 1'b0;
    logic       cs0 = 1'b1;
    logic       sck3 = 1'b1;
    logic       cs3 = 1'b1;
    logic       rx_dv0;
    logic       rx_dv3;
    logic [7:0] rx_byte0;
    logic [7:0] rx_byte3;
    wire        miso0;
    wire        miso3;

    // A released MISO reads as 1 through the pullup.
    pullup (miso0);
    pullup (miso3);

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rx_exp_t;

    rx_exp_t q0[$];
    rx_exp_t q3[$];

    spi_slave #(.SPI_MODE(0)) dut0 (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .o_RX_DV    (rx_dv0),
        .o_RX_Byte  (rx_byte0),
        .i_TX_DV    (tx_dv),
        .i_TX_Byte  (tx_byte),
        .i_SPI_Clk  (sck0),
        .o_SPI_MISO (miso0),
        .i_SPI_MOSI (mosi),
        .i_SPI_CS_n (cs0)
    );

    spi_slave #(.SPI_MODE(3)) dut3 (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .o_RX_DV    (rx_dv3),
        .o_RX_Byte  (rx_byte3),
        .i_TX_DV    (tx_dv),
        .i_TX_Byte  (tx_byte),
        .i_SPI_Clk  (sck3),
        .o_SPI_MISO (miso3),
        .i_SPI_MOSI (mosi),
        .i_SPI_CS_n (cs3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the mode-0 instance.
    always @(negedge clk) begin
        if (rx_dv0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("rx_unexpected_pulse_m0", {24'd0, rx_byte0}, 32'hFFFF_FFFF);
            end else begin
                rx_exp_t e;
                e = q0.pop_front();
                chk("rx_byte_m0", {24'd0, rx_byte0}, {24'd0, e.data});
                chk("rx_latency_m0", cyc, e.due);
            end
        end
    end

    // Monitor for the mode-3 instance.
    always @(negedge clk) begin
        if (rx_dv3 === 1'b1) begin
            if (q3.size() == 0) begin
                chk("rx_unexpected_pulse_m3", {24'd0, rx_byte3}, 32'hFFFF_FFFF);
            end else begin
                rx_exp_t e;
                e = q3.pop_front();
                chk("rx_byte_m3", {24'd0, rx_byte3}, {24'd0, e.data});
                chk("rx_latency_m3", cyc, e.due);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic set_sck(input int m, input logic v);
        if (m == 0) sck0 = v;
        else        sck3 = v;
    endtask

    task automatic set_cs(input int m, input logic v);
        if (m == 0) cs0 = v;
        else        cs3 = v;
    endtask

    function automatic logic get_miso(input int m);
        return (m == 0) ? miso0 : miso3;
    endfunction

    task automatic load_tx(input logic [7:0] b);
        tx_byte = b;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv   = 1'b0;
    endtask

    // One CS frame of nb bytes. txb[0] is loaded before CS falls; txb[k+1]
    // is loaded right after the o_RX_DV of byte k, as a host would.
    task automatic spi_frame(input int m, input int nb,
                             input logic [7:0] rxb[4], input logic [7:0] txb[4]);
        logic       cpol;
        logic       cpha;
        logic [7:0] got;
        rx_exp_t    e;
        cpol = (m == 3);
        cpha = (m == 3);
        got  = 8'h00;
        load_tx(txb[0]);
        set_cs(m, 1'b0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < nb; k++) begin
            for (int i = 7; i >= 0; i--) begin
                if (!cpha) begin
                    mosi = rxb[k][i];
                    repeat (4) @(negedge clk);
                    got[i] = get_miso(m);
                    set_sck(m, ~cpol);
                end else begin
                    set_sck(m, ~cpol);
                    mosi = rxb[k][i];
                    repeat (4) @(negedge clk);
                    got[i] = get_miso(m);
                    set_sck(m, cpol);
                end
                if (i == 0) begin
                    e.data = rxb[k];
                    e.due  = cyc + 3;
                    if (m == 0) q0.push_back(e);
                    else        q3.push_back(e);
                    repeat (3) @(negedge clk);
                    if (k + 1 < nb) begin
                        tx_byte = txb[k + 1];
                        tx_dv   = 1'b1;
                    end
                    @(negedge clk);
                    tx_dv = 1'b0;
                end else begin
                    repeat (4) @(negedge clk);
                end
                if (!cpha) set_sck(m, cpol);
            end
            chk((m == 0) ? "miso_byte_m0" : "miso_byte_m3", {24'd0, got}, {24'd0, txb[k]});
        end
        repeat (4) @(negedge clk);
        set_cs(m, 1'b1);
        repeat (6) @(negedge clk);
        chk((m == 0) ? "rx_byte_hold_m0" : "rx_byte_hold_m3",
            {24'd0, (m == 0) ? rx_byte0 : rx_byte3}, {24'd0, rxb[nb - 1]});
    endtask

    // Mode-0 partial byte: only the first n bits, CS left asserted.
    task automatic spi_bits0(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            repeat (4) @(negedge clk);
            sck0 = 1'b1;
            repeat (4) @(negedge clk);
            sck0 = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] ra[4];
        logic [7:0] ta[4];
        int         m;
        int         nb;

        repeat (3) @(negedge clk);
        chk("reset_rx_dv_m0", {31'd0, rx_dv0}, 32'd0);
        chk("reset_rx_byte_m0", {24'd0, rx_byte0}, 32'd0);
        chk("reset_rx_byte_m3", {24'd0, rx_byte3}, 32'd0);
        chk("reset_miso_z_m0", {31'd0, miso0}, 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0: receive 0xA5 while returning 0x3C; MISO released around the frame.
        load_tx(8'h3C);
        chk("miso_z_before_cs_m0", {31'd0, miso0}, 32'd1);
        ra = '{8'hA5, 8'h00, 8'h00, 8'h00};
        ta = '{8'h3C, 8'h00, 8'h00, 8'h00};
        spi_frame(0, 1, ra, ta);
        chk("miso_z_after_cs_m0", {31'd0, miso0}, 32'd1);

        // Two bytes in one frame with a reload between them.
        ra = '{8'h9F, 8'h01, 8'h00, 8'h00};
        ta = '{8'h3C, 8'hC3, 8'h00, 8'h00};
        spi_frame(0, 2, ra, ta);

        // Abort after 5 bits, then a full frame.
        cs0 = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits0(8'hFF, 5);
        repeat (4) @(negedge clk);
        cs0 = 1'b1;
        repeat (6) @(negedge clk);
        ra = '{8'h5A, 8'h00, 8'h00, 8'h00};
        ta = '{8'h66, 8'h00, 8'h00, 8'h00};
        spi_frame(0, 1, ra, ta);

        // Mode 3 instance.
        ra = '{8'h81, 8'h00, 8'h00, 8'h00};
        ta = '{8'h7E, 8'h00, 8'h00, 8'h00};
        spi_frame(3, 1, ra, ta);
        chk("miso_z_after_cs_m3", {31'd0, miso3}, 32'd1);

        // Asynchronous reset in the middle of a byte.
        load_tx(8'h55);
        cs0 = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits0(8'hB0, 4);
        rst_n = 1'b0;
        #1;
        chk("midreset_rx_dv_m0", {31'd0, rx_dv0}, 32'd0);
        chk("midreset_rx_byte_m0", {24'd0, rx_byte0}, 32'd0);
        chk("midreset_miso_z_m0", {31'd0, miso0}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        cs0 = 1'b1;
        repeat (6) @(negedge clk);
        ra = '{8'h42, 8'h00, 8'h00, 8'h00};
        ta = '{8'h99, 8'h00, 8'h00, 8'h00};
        spi_frame(0, 1, ra, ta);

        // Randomized frames in both modes.
        for (int r = 0; r < 12; r++) begin
            m  = ($urandom_range(0, 1) == 1) ? 3 : 0;
            nb = $urandom_range(1, 4);
            for (int j = 0; j < 4; j++) begin
                ra[j] = 8'($urandom);
                ta[j] = 8'($urandom);
            end
            spi_frame(m, nb, ra, ta);
        end

        repeat (10) @(negedge clk);
        chk("rx_pending_m0", q0.size(), 32'd0);
        chk("rx_pending_m3", q3.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
